// File: rtl/real_conv_sched.sv
// real_conv_sched
//   Round-robin scheduler that shares one multi-cycle real-conversion unit
//   (CU) among NUM_REQ requesters. Legal opcodes are issued to the CU and
//   its result is returned to the requester. Illegal opcodes (6, 7) are
//   answered immediately with an error, and the CU is not started for them.
//   A CU that never signals done is caught by a WAIT-cycle timeout.
//
// Ports
//   clk, rst_n             clock (rising edge), async active-low reset
//   req_valid/req_ready    per-requester handshake; req_ready is one-hot
//   req_op, req_data       packed per-requester opcode / operand slots
//   resp_valid/resp_ready  response handshake toward the consumer
//   resp_id/data/err       response payload (err: 0 OK, 1 ILLEGAL_OP, 2 TIMEOUT)
//   cu_start               one-cycle CU launch pulse
//   cu_op, cu_operand      CU inputs, held from launch until done
//   cu_done, cu_result     CU completion pulse and its result
module real_conv_sched #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 64,
    parameter int TIMEOUT = 15
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*3-1:0]      req_op,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic                      resp_valid,
    input  logic                      resp_ready,
    output logic [$clog2(NUM_REQ)-1:0] resp_id,
    output logic [DATA_W-1:0]         resp_data,
    output logic [1:0]                resp_err,
    output logic                      cu_start,
    output logic [2:0]                cu_op,
    output logic [DATA_W-1:0]         cu_operand,
    input  logic                      cu_done,
    input  logic [DATA_W-1:0]         cu_result
);
    localparam int ID_W = $clog2(NUM_REQ);

    localparam logic [1:0] ERR_OK      = 2'd0;
    localparam logic [1:0] ERR_ILLEGAL = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t              r_state;
    state_t              w_next_state;
    logic [ID_W-1:0]     r_rr_ptr;
    logic [ID_W-1:0]     r_id;
    logic [2:0]          r_op;
    logic [DATA_W-1:0]   r_operand;
    logic [DATA_W-1:0]   r_result;
    logic [1:0]          r_err;
    logic [7:0]          r_wait_cnt;

    logic                w_grant_vld;
    logic [ID_W-1:0]     w_grant_id;
    logic [2:0]          w_grant_op;
    logic [DATA_W-1:0]   w_grant_data;
    logic                w_grant_legal;
    logic                w_accept;
    logic                w_wait_hit;

    // Round-robin search: first valid requester at or after r_rr_ptr.
    always_comb begin
        int idx;
        // NOTE: combinational blocks use blocking '=' and assign every output a
        // default first, so no path leaves a signal unassigned (no latches).
        w_grant_vld = 1'b0;
        w_grant_id  = '0;
        idx         = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(r_rr_ptr) + k) % NUM_REQ;
            if (!w_grant_vld && req_valid[idx]) begin
                w_grant_vld = 1'b1;
                w_grant_id  = ID_W'(idx);
            end
        end
    end

    assign w_grant_op    = req_op[3*w_grant_id +: 3];
    assign w_grant_data  = req_data[DATA_W*w_grant_id +: DATA_W];
    assign w_grant_legal = (w_grant_op <= 3'd5);
    assign w_accept      = (r_state == S_IDLE) && w_grant_vld;
    // Counter is about to reach TIMEOUT on this WAIT cycle.
    assign w_wait_hit    = (r_wait_cnt == 8'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next state and the state-decoded outputs. req_ready is also gated by
    // rst_n so every output reads 0 while reset is held.
    always_comb begin
        w_next_state = r_state;
        req_ready    = '0;
        cu_start     = 1'b0;
        resp_valid   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_grant_vld && rst_n) begin
                    req_ready = NUM_REQ'(1) << w_grant_id;
                end
                if (w_grant_vld) begin
                    w_next_state = w_grant_legal ? S_ISSUE : S_RESP;
                end
            end
            S_ISSUE: begin
                cu_start     = 1'b1;
                w_next_state = S_WAIT;
            end
            S_WAIT: begin
                if (cu_done || w_wait_hit) begin
                    w_next_state = S_RESP;
                end
            end
            S_RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) begin
                    w_next_state = S_IDLE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // Datapath registers. cu_done is only looked at in WAIT, so late or
    // spurious done pulses have no effect.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: these are plain control/data registers (not a memory array), so
        // they are all cleared by the async reset and use non-blocking '<='.
        if (!rst_n) begin
            r_rr_ptr   <= '0;
            r_id       <= '0;
            r_op       <= '0;
            r_operand  <= '0;
            r_result   <= '0;
            r_err      <= ERR_OK;
            r_wait_cnt <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_id      <= w_grant_id;
                        r_op      <= w_grant_op;
                        r_operand <= w_grant_data;
                        r_rr_ptr  <= (w_grant_id == ID_W'(NUM_REQ - 1)) ?
                                     '0 : w_grant_id + 1'b1;
                        if (!w_grant_legal) begin
                            r_result <= '0;
                            r_err    <= ERR_ILLEGAL;
                        end
                    end
                end
                S_ISSUE: begin
                    r_wait_cnt <= '0;
                end
                S_WAIT: begin
                    // A done arriving on the timeout cycle still wins.
                    if (cu_done) begin
                        r_result <= cu_result;
                        r_err    <= ERR_OK;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 8'd1;
                        if (w_wait_hit) begin
                            r_result <= '0;
                            r_err    <= ERR_TIMEOUT;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign resp_id    = r_id;
    assign resp_data  = r_result;
    assign resp_err   = r_err;
    assign cu_op      = r_op;
    assign cu_operand = r_operand;

endmodule

// File: tb/tb_real_conv_sched.sv
// tb_real_conv_sched
//   Directed bench for real_conv_sched. A behavioural CU returns a known
//   function of op/operand after cu_lat cycles (0 = never). Each accepted
//   request pushes its expected response into a scoreboard queue; each
//   response handshake pops and compares.
module tb_real_conv_sched;
    localparam int NUM_REQ = 4;
    localparam int DATA_W  = 64;
    localparam int TIMEOUT = 15;

    typedef struct {
        logic [1:0]  id;
        logic [63:0] data;
        logic [1:0]  err;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [3:0]   req_valid;
    logic [3:0]   req_ready;
    logic [11:0]  req_op;
    logic [255:0] req_data;
    logic         resp_valid;
    logic         resp_ready;
    logic [1:0]   resp_id;
    logic [63:0]  resp_data;
    logic [1:0]   resp_err;
    logic         cu_start;
    logic [2:0]   cu_op;
    logic [63:0]  cu_operand;
    logic         cu_done;
    logic [63:0]  cu_result;

    exp_t sb[$];
    int   grants[$];
    int   checks = 0;
    int   failures = 0;
    int   cu_lat = 3;
    int   start_cnt = 0;

    real_conv_sched #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_data(req_data),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_id(resp_id), .resp_data(resp_data), .resp_err(resp_err),
        .cu_start(cu_start), .cu_op(cu_op), .cu_operand(cu_operand),
        .cu_done(cu_done), .cu_result(cu_result)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] cu_model(input logic [2:0] op, input logic [63:0] d);
        return {d[60:0], op} ^ 64'hA5A5_5A5A_0F0F_F0F0;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Behavioural CU.
    initial begin
        int pend = 0;
        cu_done   = 1'b0;
        cu_result = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                pend    = 0;
                cu_done = 1'b0;
            end else begin
                cu_done = 1'b0;
                if (pend > 0) begin
                    pend--;
                    if (pend == 0) begin
                        cu_done   = 1'b1;
                        cu_result = cu_model(cu_op, cu_operand);
                    end
                end
                if (cu_start) begin
                    start_cnt++;
                    pend = cu_lat;
                end
            end
        end
    end

    // Scoreboard monitor: push on grant, pop on response.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (resp_valid || cu_start) check("ready_while_busy", req_ready, 0);
                if (resp_valid && resp_ready) begin
                    if (sb.size() == 0) begin
                        check("resp_unexpected", resp_valid, 0);
                    end else begin
                        e = sb.pop_front();
                        check("resp_id", resp_id, e.id);
                        check("resp_data", resp_data, e.data);
                        check("resp_err", resp_err, e.err);
                    end
                end
                if (req_ready != '0) begin
                    check("grant_onehot",
                          $onehot(req_ready) && ((req_ready & ~req_valid) == '0), 1);
                    for (int i = 0; i < NUM_REQ; i++) begin
                        if (req_ready[i]) begin
                            logic [2:0] op;
                            op     = req_op[3*i +: 3];
                            e.id   = 2'(i);
                            e.err  = (op > 3'd5) ? 2'd1 :
                                     ((cu_lat == 0 || cu_lat > TIMEOUT) ? 2'd2 : 2'd0);
                            e.data = (e.err != 2'd0) ? 64'd0 : cu_model(op, req_data[64*i +: 64]);
                            sb.push_back(e);
                            grants.push_back(i);
                        end
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Call at posedge+1; returns at posedge+1 just after the accepting edge.
    task automatic submit(input int id, input logic [2:0] op, input logic [63:0] d);
        bit ok;
        ok = 1'b0;
        req_op[3*id +: 3]    = op;
        req_data[64*id +: 64] = d;
        req_valid[id]        = 1'b1;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            if (req_ready[id]) ok = 1'b1;
        end
        step();
        req_valid[id] = 1'b0;
        check("accept", ok, 1);
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && (sb.size() != 0 || resp_valid); i++) step();
        check("drain", sb.size(), 0);
    endtask

    initial begin
        int n;
        int s;
        rst_n      = 1'b0;
        req_valid  = '0;
        req_op     = '0;
        req_data   = '0;
        resp_ready = 1'b1;
        #2;
        check("rst_req_ready", req_ready, 0);
        check("rst_resp_valid", resp_valid, 0);
        check("rst_cu_start", cu_start, 0);
        check("rst_resp_data", resp_data, 0);
        #21 rst_n = 1'b1;
        step();

        // Round-robin with all four requesting from rr_ptr=0.
        cu_lat = 2;
        grants.delete();
        for (int i = 0; i < NUM_REQ; i++) begin
            req_op[3*i +: 3]    = 3'(i);
            req_data[64*i +: 64] = 64'h1000 + 64'(i);
        end
        req_valid = 4'hF;
        for (int i = 0; i < 300 && grants.size() < 5; i++) @(negedge clk);
        step();
        req_valid = '0;
        check("rr_grant_count", grants.size(), 5);
        for (int i = 0; i < 5 && i < grants.size(); i++) check("rr_order", grants[i], i % 4);
        drain();

        // Single request, CU done 3 cycles after start.
        cu_lat = 3;
        submit(0, 3'd0, 64'd5);
        check("start_after_accept", cu_start, 1);
        drain();

        // Illegal opcode: immediate response, CU untouched.
        s = start_cnt;
        submit(2, 3'd7, 64'hDEAD);
        check("illegal_resp_next", resp_valid, 1);
        check("illegal_no_start", cu_start, 0);
        drain();
        check("illegal_start_cnt", start_cnt, s);

        // CU never completes: timeout after exactly TIMEOUT WAIT cycles.
        cu_lat = 0;
        submit(1, 3'd4, 64'h55);
        check("to_start", cu_start, 1);
        n = 0;
        for (int i = 1; i <= 40 && n == 0; i++) begin
            step();
            if (resp_valid) n = i;
        end
        check("to_latency", n, TIMEOUT + 1);
        drain();

        // Done on the very cycle the counter reaches TIMEOUT: done wins.
        cu_lat = TIMEOUT;
        submit(3, 3'd2, 64'h1234_5678_9ABC_DEF0);
        drain();

        // Late done after timeout while the response is stalled 10 cycles.
        cu_lat     = TIMEOUT + 1;
        resp_ready = 1'b0;
        submit(3, 3'd5, 64'hCAFE);
        for (int i = 0; i < 40 && !resp_valid; i++) step();
        req_valid[0] = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            check("stall_valid", resp_valid, 1);
            check("stall_ready", req_ready, 0);
            if (sb.size() > 0) begin
                check("stall_id", resp_id, sb[0].id);
                check("stall_data", resp_data, sb[0].data);
                check("stall_err", resp_err, sb[0].err);
            end
        end
        resp_ready   = 1'b1;
        req_valid[0] = 1'b0;
        drain();
        for (int i = 0; i < 3; i++) step();
        check("late_done_no_resp", resp_valid, 0);

        // Reset during ISSUE: cu_start drops asynchronously.
        cu_lat = 0;
        submit(0, 3'd1, 64'h77);
        check("pre_rst_start", cu_start, 1);
        #2 rst_n = 1'b0;
        #1;
        check("rst_async_start", cu_start, 0);
        sb.delete();
        step();
        #2 rst_n = 1'b1;
        step();

        // Reset during WAIT, then the next grant starts from req0.
        submit(2, 3'd2, 64'h99);
        step();
        step();
        #2 rst_n = 1'b0;
        #1;
        check("rst_wait_req_ready", req_ready, 0);
        check("rst_wait_resp_valid", resp_valid, 0);
        check("rst_wait_resp_id", resp_id, 0);
        check("rst_wait_resp_err", resp_err, 0);
        check("rst_wait_cu_op", cu_op, 0);
        check("rst_wait_cu_operand", cu_operand, 0);
        sb.delete();
        step();
        #2 rst_n = 1'b1;
        step();
        cu_lat = 2;
        req_op[2:0]     = 3'd0;
        req_op[11:9]    = 3'd3;
        req_data[63:0]  = 64'hA0;
        req_data[255:192] = 64'hA3;
        req_valid = 4'b1001;
        @(negedge clk);
        check("post_rst_grant", req_ready, 4'b0001);
        step();
        req_valid = '0;
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
